// File: rtl/bp_pkg.sv
// Shared constants for the branch history table predictor.
// Counter encodings and the conditional-branch opcode.
package bp_pkg;
  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/branch_predictor_bht_if.sv
// ID/EX/hazard-side bundle of the branch predictor.
// master = pipeline side, slave = predictor.
interface bp_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [6:0]       id_op;
  logic [31:0]      id_pc;
  logic             predict_taken;
  logic             ex_valid;
  logic             ex_is_branch;
  logic [31:0]      ex_pc;
  logic             ex_taken;
  logic             ex_predicted;
  logic             stall;
  logic             correct;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output id_valid, id_op, id_pc,
    output ex_valid, ex_is_branch, ex_pc,
    output ex_taken, ex_predicted, stall,
    input  predict_taken, correct,
    input  br_count, miss_count
  );

  modport slave (
    input  id_valid, id_op, id_pc,
    input  ex_valid, ex_is_branch, ex_pc,
    input  ex_taken, ex_predicted, stall,
    output predict_taken, correct,
    output br_count, miss_count
  );
endinterface

// File: rtl/branch_predictor_bht_sat_counter2.sv
// 2-bit saturating counter next-state function.
// Counts up on taken, down on not-taken, clamps at both ends.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt_in,
  input  logic       taken,
  output logic [1:0] cnt_out
);
  always_comb begin
    cnt_out = cnt_in;
    unique case (1'b1)
      taken && (cnt_in != CNT_ST):
        cnt_out = cnt_in + 2'd1;
      !taken && (cnt_in != CNT_SNT):
        cnt_out = cnt_in - 2'd1;
      default: ;
    endcase
  end
endmodule

// File: rtl/branch_predictor_bht.sv
// PC-indexed table of 2-bit counters: predict in ID,
// resolve and train in EX, count branches and misses.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int IDX_W    = 6,
  parameter int INIT_CNT = 1,
  parameter int CNT_W    = 32
) (
  input logic clk,
  input logic rst,
  bp_if.slave bus
);
  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0]       cnt [ENTRIES];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       cnt_nxt;
  logic             res;
  logic             miss;
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] miss_q;

  assign rd_idx = bus.id_pc[IDX_W+1:2];
  assign wr_idx = bus.ex_pc[IDX_W+1:2];

  assign res  = bus.ex_valid & bus.ex_is_branch;
  assign miss = res & (bus.ex_taken != bus.ex_predicted);

  // Read sees the pre-update entry; no write bypass.
  assign bus.predict_taken = ~rst & bus.id_valid
                           & (bus.id_op == OP_BRANCH)
                           & cnt[rd_idx][1];
  assign bus.correct = rst | ~miss;

  sat_counter2 u_sat (
    .cnt_in  (cnt[wr_idx]),
    .taken   (bus.ex_taken),
    .cnt_out (cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        cnt[i] <= 2'(INIT_CNT);
    end else if (res) begin
      cnt[wr_idx] <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q   <= '0;
      miss_q <= '0;
    end else if (res && !bus.stall) begin
      br_q   <= br_q + CNT_W'(1);
      miss_q <= miss_q + CNT_W'(miss);
    end
  end

  assign bus.br_count   = br_q;
  assign bus.miss_count = miss_q;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomized scoreboard bench for branch_predictor_bht
// against a strength-array reference model.
module tb_branch_predictor_bht;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] ALU = 7'b0110011;

  typedef struct {
    logic        p;
    logic        c;
    logic [31:0] b;
    logic [31:0] m;
    bit          known;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_if #(.CNT_W(32)) bus ();

  branch_predictor_bht #(
    .IDX_W(6), .INIT_CNT(1), .CNT_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned strength [64];
  int unsigned m_br = 0;
  int unsigned m_ms = 0;
  bit          known = 0;

  task automatic step(
    input bit r, input bit iv, input logic [6:0] op,
    input logic [31:0] ipc, input bit ev, input bit eb,
    input logic [31:0] epc, input bit et, input bit ep,
    input bit st);
    exp_t e;
    bit   rs;
    bit   ms;
    int   k;
    @(negedge clk);
    rst = r;
    bus.id_valid = iv;
    bus.id_op = op;
    bus.id_pc = ipc;
    bus.ex_valid = ev;
    bus.ex_is_branch = eb;
    bus.ex_pc = epc;
    bus.ex_taken = et;
    bus.ex_predicted = ep;
    bus.stall = st;
    rs = ev && eb;
    ms = rs && (et != ep);
    e.p = !r && iv && (op == BR)
        && (strength[(ipc / 4) % 64] >= 2);
    e.c = r || !ms;
    e.b = m_br;
    e.m = m_ms;
    e.known = known;
    #1 q.push_back(e);
    if (r) begin
      foreach (strength[i]) strength[i] = 1;
      m_br = 0;
      m_ms = 0;
      known = 1;
    end else if (rs) begin
      k = int'((epc / 4) % 64);
      if (et) strength[k] = (strength[k] == 3) ? 3 : strength[k] + 1;
      else strength[k] = (strength[k] == 0) ? 0 : strength[k] - 1;
      if (!st) begin
        m_br = m_br + 1;
        if (ms) m_ms = m_ms + 1;
      end
    end
  endtask

  task automatic look(input logic [31:0] pc);
    step(0, 1, BR, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [31:0] ipc,
    input logic [31:0] epc, input bit et, input bit ep,
    input bit st);
    step(0, 1, BR, ipc, 1, 1, epc, et, ep, st);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (bus.predict_taken !== e.p) begin
          bad++;
          $display("FAIL predict_taken t=%0t got=%b want=%b",
                   $time, bus.predict_taken, e.p);
        end
        total++;
        if (bus.correct !== e.c) begin
          bad++;
          $display("FAIL correct t=%0t got=%b want=%b",
                   $time, bus.correct, e.c);
        end
        if (e.known) begin
          total++;
          if (bus.br_count !== e.b) begin
            bad++;
            $display("FAIL br_count t=%0t got=%0d want=%0d",
                     $time, bus.br_count, e.b);
          end
          total++;
          if (bus.miss_count !== e.m) begin
            bad++;
            $display("FAIL miss_count t=%0t got=%0d want=%0d",
                     $time, bus.miss_count, e.m);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [31:0] pcs [5];
    logic [31:0] ipc;
    logic [31:0] epc;
    pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h140;
    pcs[3] = 32'h44; pcs[4] = 32'h1040;
    rst = 1'b1;
    bus.id_valid = 0; bus.id_op = 0; bus.id_pc = 0;
    bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_pc = 0;
    bus.ex_taken = 0; bus.ex_predicted = 0; bus.stall = 0;
    // reset, then first lookup at WNT
    step(1, 1, BR, 32'h40, 0, 0, 0, 0, 0, 0);
    look(32'h40);
    // mispredicted taken, then lookup sees WT
    resolve(32'h40, 32'h40, 1, 0, 0);
    look(32'h40);
    // saturate, then walk back down
    repeat (4) resolve(32'h40, 32'h40, 1, 1, 0);
    resolve(32'h40, 32'h40, 0, 1, 0);
    look(32'h40);
    resolve(32'h40, 32'h40, 0, 1, 0);
    look(32'h40);
    // same-index read/write in one cycle
    resolve(32'h80, 32'h80, 1, 0, 0);
    look(32'h80);
    // aliasing 0x40 / 0x140 and a non-branch opcode
    resolve(32'h140, 32'h140, 1, 0, 0);
    look(32'h40);
    step(0, 1, ALU, 32'h40, 0, 0, 0, 0, 0, 0);
    resolve(32'h140, 32'h140, 0, 1, 0);
    resolve(32'h140, 32'h140, 0, 0, 0);
    look(32'h40);
    // stall during a mispredict, then reset during a resolve
    resolve(32'h80, 32'h80, 0, 1, 1);
    look(32'h80);
    step(1, 1, BR, 32'h80, 1, 1, 32'h80, 1, 0, 0);
    look(32'h80);
    look(32'h40);
    // non-branch in EX, bubble in ID
    step(0, 0, BR, 32'h80, 1, 0, 32'h80, 1, 0, 0);
    look(32'h80);
    for (int n = 0; n < 800; n++) begin
      ipc = pcs[$urandom_range(0, 4)];
      epc = pcs[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) ipc = $urandom;
      if ($urandom_range(0, 7) == 0) epc = $urandom;
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 5) != 0,
           ($urandom_range(0, 4) == 0) ? ALU : BR,
           ipc,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           epc,
           1'($urandom), 1'($urandom),
           $urandom_range(0, 4) == 0);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
